color_accumulator: RTL

- Upstream feeder for the insertion sorter in the image sorting engine.
- Consumes a stream of 24-bit RGB pixels and sums each 8-bit channel over every image.
- When an image completes, emits three {color, total, index} records, one per color and one per cycle, on the sorter's in_valid/color/total/index inputs.
- Honours the sorter's busy signal and backpressures the pixel source when its output buffer is still draining.

---
 rtl/color_accumulator.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/color_accumulator.sv
// Sums the R/G/B channels of every image in a pixel stream and hands the three channel
// totals to the insertion sorter as {color, total, index} records, one per cycle.
module color_accumulator #(
  parameter int unsigned PIXELS     = 32768,
  parameter int unsigned PIX_CNT_W  = 15,
  parameter int unsigned NUM_IMAGES = 32,
  parameter int unsigned TOTAL_W    = 23
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [23:0]        pixel_in,
  input  logic               pixel_valid,
  output logic               pixel_ready,
  input  logic               sorter_busy,
  output logic [1:0]         color,
  output logic [TOTAL_W-1:0] total,
  output logic [4:0]         index,
  output logic               out_valid,
  output logic               done
);

  typedef enum logic {StIdle, StEmit} state_e;

  state_e               state_q, state_d;
  logic [1:0]           ptr_q, ptr_d;
  logic [PIX_CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [4:0]           img_q, img_d;
  logic [4:0]           buf_idx_q, buf_idx_d;
  logic [TOTAL_W-1:0]   acc_q [3];
  logic [TOTAL_W-1:0]   acc_d [3];
  logic [TOTAL_W-1:0]   buf_q [3];
  logic [TOTAL_W-1:0]   buf_d [3];
  logic [TOTAL_W-1:0]   sum   [3];
  logic [1:0]           color_q, color_d;
  logic [TOTAL_W-1:0]   total_q, total_d;
  logic [4:0]           index_q, index_d;
  logic                 out_valid_q, out_valid_d;
  logic                 done_q, done_d;

  logic last_pix;
  logic accept;

  function automatic logic [TOTAL_W-1:0] sat_add(input logic [TOTAL_W-1:0] a,
                                                 input logic [7:0] b);
    logic [TOTAL_W:0] s;
    s = {1'b0, a} + {{(TOTAL_W - 7){1'b0}}, b};
    return s[TOTAL_W] ? {TOTAL_W{1'b1}} : s[TOTAL_W-1:0];
  endfunction

  assign last_pix    = (pix_cnt_q == PIX_CNT_W'(PIXELS - 1));
  // Conservative: the final pixel of an image waits until the previous image fully drained.
  assign pixel_ready = !(last_pix && (state_q == StEmit));
  assign accept      = pixel_valid && pixel_ready;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    pix_cnt_d   = pix_cnt_q;
    img_d       = img_q;
    buf_idx_d   = buf_idx_q;
    color_d     = color_q;
    total_d     = total_q;
    index_d     = index_q;
    out_valid_d = 1'b0;
    done_d      = 1'b0;
    for (int i = 0; i < 3; i++) begin
      acc_d[i] = acc_q[i];
      buf_d[i] = buf_q[i];
      sum[i]   = sat_add(acc_q[i], pixel_in[23 - 8 * i -: 8]);
    end

    unique case (state_q)
      StIdle: ;
      StEmit: begin
        if (!sorter_busy) begin
          color_d     = ptr_q;
          total_d     = buf_q[ptr_q];
          index_d     = buf_idx_q;
          out_valid_d = 1'b1;
          if (ptr_q == 2'd2) begin
            state_d = StIdle;
            ptr_d   = 2'd0;
            done_d  = (buf_idx_q == 5'(NUM_IMAGES - 1));
          end else begin
            ptr_d = ptr_q + 2'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Capture only happens from StIdle, so it never collides with the emission above.
    if (accept) begin
      if (last_pix) begin
        for (int i = 0; i < 3; i++) begin
          buf_d[i] = sum[i];
          acc_d[i] = '0;
        end
        buf_idx_d = img_q;
        state_d   = StEmit;
        ptr_d     = 2'd0;
        pix_cnt_d = '0;
        img_d     = (img_q == 5'(NUM_IMAGES - 1)) ? 5'd0 : img_q + 5'd1;
      end else begin
        for (int i = 0; i < 3; i++) acc_d[i] = sum[i];
        pix_cnt_d = pix_cnt_q + PIX_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= 2'd0;
      pix_cnt_q   <= '0;
      img_q       <= 5'd0;
      buf_idx_q   <= 5'd0;
      color_q     <= 2'd0;
      total_q     <= '0;
      index_q     <= 5'd0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        acc_q[i] <= '0;
        buf_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      pix_cnt_q   <= pix_cnt_d;
      img_q       <= img_d;
      buf_idx_q   <= buf_idx_d;
      color_q     <= color_d;
      total_q     <= total_d;
      index_q     <= index_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      for (int i = 0; i < 3; i++) begin
        acc_q[i] <= acc_d[i];
        buf_q[i] <= buf_d[i];
      end
    end
  end

  assign color     = color_q;
  assign total     = total_q;
  assign index     = index_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;

endmodule
